volume_meter_peak_hold: RTL

Parametrised windowed peak-level meter for the audio visualizer. It tracks the maximum sample amplitude over a fixed window of accepted samples and quantises it to a bar level saturated at `NUM_BARS`. It maintains a peak-hold marker that decays after a hold time and exposes a thermometer bar mask. It sits between the sample path (`clk_sample` domain) and the VGA bar renderer, which consumes `level`, `peak_level` and `bar_mask`.

---
 rtl/volume_meter_peak_hold.sv | 123 ++++++++++++
 1 files changed

// File: rtl/volume_meter_peak_hold.sv
// Windowed peak-level meter with a decaying peak-hold marker. level, peak_level and window_done register one cycle after the closing sample.
// freeze stalls all state; no backpressure. VOLUME_METER_PEAK_HOLD_EN enables hold/decay, otherwise peak_level mirrors level.
module volume_meter_peak_hold #(
  parameter int SAMPLE_W     = 10,
  parameter int WINDOW       = 2000,
  parameter int NUM_BARS     = 12,
  parameter int LEVEL_SHIFT  = 4,
  parameter int RECTIFY      = 0,
  parameter int HOLD_WINDOWS = 8,
  localparam int LEVEL_W     = $clog2(NUM_BARS + 1)
) (
  input  logic                clk_sample,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] wave_sample,
  input  logic                freeze,
  output logic [LEVEL_W-1:0]  level,
  output logic [LEVEL_W-1:0]  peak_level,
  output logic [NUM_BARS-1:0] bar_mask,
  output logic                window_done
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(1) << (SAMPLE_W - 1);

  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] mx;
  logic [SAMPLE_W-1:0] amp;
  logic [SAMPLE_W-1:0] wmax;
  logic [SAMPLE_W-1:0] shifted;
  logic [LEVEL_W-1:0]  lvl_new;
  logic                accept;
  logic                close;

  always_comb begin
    amp = wave_sample;
    if (RECTIFY != 0) begin
      amp = (wave_sample >= MID) ? (wave_sample - MID) : (MID - wave_sample);
    end
  end

  // The closing sample participates in its own window's max.
  always_comb begin
    wmax    = (amp > mx) ? amp : mx;
    shifted = wmax >> LEVEL_SHIFT;
    lvl_new = (32'(shifted) > 32'(NUM_BARS)) ? LEVEL_W'(NUM_BARS) : LEVEL_W'(shifted);
    accept  = sample_en && !freeze;
    close   = accept && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk_sample) begin
    if (reset) begin
      cnt         <= '0;
      mx          <= '0;
      level       <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (accept) begin
        if (close) begin
          cnt         <= '0;
          mx          <= '0;
          level       <= lvl_new;
          window_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          mx  <= wmax;
        end
      end
    end
  end

`ifdef VOLUME_METER_PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_WINDOWS < 1) ? 1 : $clog2(HOLD_WINDOWS + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_WINDOWS);

  typedef enum logic [1:0] {TRACK, HOLD, DECAY} peak_state_t;

  peak_state_t        state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [LEVEL_W-1:0] peak_dec;

  always_comb peak_dec = peak_level - 1'b1;

  // HOLD is kept exactly when hold_cnt is non-zero, so the state alone picks the branch.
  always_ff @(posedge clk_sample) begin
    if (reset) begin
      state      <= TRACK;
      hold_cnt   <= '0;
      peak_level <= '0;
    end else if (close) begin
      if (lvl_new >= peak_level) begin
        peak_level <= lvl_new;
        hold_cnt   <= HOLD_RELOAD;
        state      <= (HOLD_WINDOWS > 0) ? HOLD : TRACK;
      end else begin
        case (state)
          HOLD: begin
            hold_cnt <= hold_cnt - 1'b1;
            state    <= (hold_cnt == HOLD_W'(1)) ? DECAY : HOLD;
          end
          default: begin
            // lvl_new < peak here, so one step down never undershoots it.
            peak_level <= peak_dec;
            state      <= (peak_dec == lvl_new) ? TRACK : DECAY;
          end
        endcase
      end
    end
  end
`else
  assign peak_level = level;
`endif

  always_comb begin
    bar_mask = '0;
    for (int k = 0; k < NUM_BARS; k++) begin
      bar_mask[k] = (int'(level) > k);
    end
  end

endmodule
